cnt_snapshot_serializer: RTL and testbench
==========================================

# cnt_snapshot_serializer

Downstream consumer of the 8-bit loadable counter. On a start request it captures the counter's current value and shifts it out MSB-first on a 3-wire SPI-style link (cs_n, sclk, sdo), so an external device can read the count through dedicated output pins. It provides a busy/done handshake toward the control logic and ignores new requests while a transfer is in flight.

## Interface
- WIDTH, 8: width of the captured count and of the shift register.
- HALF_PERIOD, 2: clk cycles per sclk half-period; legal range 1..255.

Ports:
- clk  in  1  system clock; all state on its rising edge.
- arst  in  1  reset, asynchronous, active-high.
- cnt_in  in  WIDTH  live counter value, sampled only at capture.
- start  in  1  level request; sampled only in IDLE.
- busy  out  1  high for the whole transfer.
- done  out  1  one-cycle pulse when a transfer completes.
- cs_n  out  1  chip select, active-low.
- sclk  out  1  serial clock; idle low (mode 0).
- sdo  out  1  serial data; changes on sclk falling edge, stable across the rising edge.

## Operation
- States: IDLE, SHIFT (plus PARITY when SER_PARITY_EN is defined).
- IDLE, start=1 at an edge: shift_reg <= cnt_in; sdo <= cnt_in[WIDTH-1]; cs_n <= 0; busy <= 1; sclk stays 0; bit_cnt <= 0; half_cnt <= 0; go to SHIFT.
- SHIFT: half_cnt counts 0..HALF_PERIOD-1. At wrap:
  - sclk=0: set sclk to 1 (receiver samples).
  - sclk=1: set sclk to 0, then take one of two actions:
    - if bit_cnt < WIDTH-1: shift left and drive the next bit on sdo.
    - else: end the data phase.
- End of data: IDLE with cs_n <= 1, busy <= 0, done <= 1, sdo <= 0. With parity enabled the flow goes to PARITY instead.
- done clears on the following cycle.
- start in SHIFT/PARITY: ignored, no queuing.
- cnt_in changes after capture: no effect on the current transfer.
- Back-to-back: start held high produces a new capture on the edge after done. cs_n is high for exactly one cycle between frames.
- arst asserted (including mid-transfer): immediately IDLE; cs_n=1, sclk=0, sdo=0, busy=0, done=0, all counters 0. No done pulse for an aborted frame.

## Timing
- Reset values: cs_n=1, sclk=0, sdo=0, busy=0, done=0.
- Capture edge to first sclk rise: HALF_PERIOD cycles.
- Bits per frame N = WIDTH (WIDTH+1 with parity). Each bit occupies 2·HALF_PERIOD cycles.
- busy is high for exactly 2·HALF_PERIOD·N cycles.
- done is asserted in the first cycle busy is low.
- Data setup and hold to sclk rise/fall: HALF_PERIOD cycles each.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- SER_PARITY_EN defined: a PARITY state appends one even-parity bit after the LSB.
  - Bit value = XOR of the captured word, computed at capture.
  - It gets one extra sclk period; N = WIDTH+1.
- SER_PARITY_EN undefined: no PARITY state, no parity register; N = WIDTH.

## Structure
- Shared package cnt_ser_pkg holds:
  - the state enum (IDLE, SHIFT, PARITY);
  - the HALF_PERIOD width constant (8 bits);
  - the reset-value constants for the serial outputs.
- One sub-module, ser_half_tick: half-period counter producing a single-cycle tick.
  - Enabled only in SHIFT/PARITY.
  - Cleared on capture and on arst.
- The parent owns the FSM, shift register, bit counter and output registers.

## Test plan
- Reset values: arst high → cs_n=1, sclk=0, sdo=0, busy=0, done=0. After release with start=0 they stay so for 50 cycles.
- Basic frame (WIDTH=8, HALF_PERIOD=2, no parity): cnt_in=0xA5, 1-cycle start.
  - sdo sampled on 8 sclk rises = 1,0,1,0,0,1,0,1.
  - busy high 32 cycles, then done=1 for one cycle.
- Ignore and isolation: start pulsed and cnt_in changed to 0x3C mid-frame → frame still shifts 0xA5; no second frame.
- Back-to-back: start held high, cnt_in=0x01 then 0xFF → two frames, cs_n high exactly 1 cycle between them, two done pulses.
- Reset mid-transfer: arst asserted after 3rd sclk rise → outputs at reset values the same cycle; no done; next start sends a full 8-bit frame.
- Parity (SER_PARITY_EN): 0xA5 → 9th bit 0; 0x07 → 9th bit 1; busy 36 cycles.

Source files
------------

// File: rtl/cnt_ser_pkg.sv
// cnt_ser_pkg
//   Shared definitions for the counter snapshot serializer: FSM state
//   encoding, half-period counter width and the idle/reset levels of the
//   serial link outputs.
package cnt_ser_pkg;

   // PARITY is only reachable when SER_PARITY_EN is defined.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2
   } ser_state_t;

   // Width of the half-period counter; HALF_PERIOD must fit (1..255).
   localparam int unsigned HP_W = 8;

   // Idle / reset levels of the registered outputs.
   localparam logic CS_N_RST = 1'b1;
   localparam logic SCLK_RST = 1'b0;
   localparam logic SDO_RST  = 1'b0;
   localparam logic BUSY_RST = 1'b0;
   localparam logic DONE_RST = 1'b0;

endpackage : cnt_ser_pkg

// File: rtl/ser_half_tick.sv
// ser_half_tick
//   Half-period timer for the serial clock. Counts 0..HALF_PERIOD-1 while
//   enabled and flags the last count with a single-cycle tick, then wraps.
//
// Ports:
//   clk   in  system clock
//   arst  in  asynchronous active-high reset
//   en    in  count enable (high while a frame is being shifted)
//   clr   in  synchronous clear, used on capture so every frame starts aligned
//   tick  out high for one cycle at the end of each half-period
module ser_half_tick
   import cnt_ser_pkg::*;
#(
   parameter int unsigned HALF_PERIOD = 2
) (
   input  logic clk,
   input  logic arst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam logic [HP_W-1:0] LAST_CNT = HP_W'(HALF_PERIOD - 1);

   logic [HP_W-1:0] half_cnt;

   assign tick = en && (half_cnt == LAST_CNT);

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         half_cnt <= '0;
      end else if (clr || tick) begin
         half_cnt <= '0;
      end else if (en) begin
         half_cnt <= half_cnt + HP_W'(1);
      end
   end

endmodule : ser_half_tick

// File: rtl/cnt_snapshot_serializer.sv
// cnt_snapshot_serializer
//   Captures the live counter value on a start request and shifts it out
//   MSB-first on a 3-wire mode-0 SPI-style link (cs_n, sclk, sdo), with a
//   busy/done handshake. Requests arriving during a frame are dropped.
//
//   Optional feature: define SER_PARITY_EN to append one even-parity bit
//   (XOR of the captured word) after the LSB, in a dedicated PARITY state.
//
// Parameters:
//   WIDTH        captured word / shift register width (>= 2)
//   HALF_PERIOD  clk cycles per sclk half-period (1..255)
//
// Ports:
//   clk     in  system clock, all state on rising edge
//   arst    in  asynchronous active-high reset; aborts any frame silently
//   cnt_in  in  counter value, sampled only at capture
//   start   in  level request, sampled only when idle
//   busy    out high for the whole frame
//   done    out one-cycle pulse in the first cycle after busy drops
//   cs_n    out chip select, active-low
//   sclk    out serial clock, idles low
//   sdo     out serial data, updated on sclk falling edge
module cnt_snapshot_serializer
   import cnt_ser_pkg::*;
#(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned HALF_PERIOD = 2
) (
   input  logic             clk,
   input  logic             arst,
   input  logic [WIDTH-1:0] cnt_in,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             cs_n,
   output logic             sclk,
   output logic             sdo
);

   localparam int unsigned     BC_W     = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WIDTH - 1);

   ser_state_t       state;
   logic [WIDTH-1:0] shift_reg;
   logic [BC_W-1:0]  bit_cnt;
   logic             capture;
   logic             half_tick;
`ifdef SER_PARITY_EN
   logic             parity_bit;
`endif

   assign capture = (state == IDLE) && start;

   ser_half_tick #(
      .HALF_PERIOD (HALF_PERIOD)
   ) u_half_tick (
      .clk  (clk),
      .arst (arst),
      .en   (state != IDLE),
      .clr  (capture),
      .tick (half_tick)
   );

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state     <= IDLE;
         shift_reg <= '0;
         bit_cnt   <= '0;
         cs_n      <= CS_N_RST;
         sclk      <= SCLK_RST;
         sdo       <= SDO_RST;
         busy      <= BUSY_RST;
         done      <= DONE_RST;
`ifdef SER_PARITY_EN
         parity_bit <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               sclk <= SCLK_RST;
               if (start) begin
                  shift_reg <= cnt_in;
                  sdo       <= cnt_in[WIDTH-1];
                  cs_n      <= 1'b0;
                  busy      <= 1'b1;
                  bit_cnt   <= '0;
`ifdef SER_PARITY_EN
                  parity_bit <= ^cnt_in;
`endif
                  state     <= SHIFT;
               end
            end

            SHIFT: begin
               if (half_tick) begin
                  if (!sclk) begin
                     sclk <= 1'b1;
                  end else begin
                     sclk <= 1'b0;
                     if (bit_cnt < LAST_BIT) begin
                        // Next bit is read from the pre-shift register so
                        // sdo and shift_reg update on the same edge.
                        shift_reg <= shift_reg << 1;
                        sdo       <= shift_reg[WIDTH-2];
                        bit_cnt   <= bit_cnt + BC_W'(1);
                     end else begin
`ifdef SER_PARITY_EN
                        sdo   <= parity_bit;
                        state <= PARITY;
`else
                        state <= IDLE;
                        cs_n  <= CS_N_RST;
                        busy  <= BUSY_RST;
                        sdo   <= SDO_RST;
                        done  <= 1'b1;
`endif
                     end
                  end
               end
            end

`ifdef SER_PARITY_EN
            PARITY: begin
               if (half_tick) begin
                  if (!sclk) begin
                     sclk <= 1'b1;
                  end else begin
                     sclk  <= 1'b0;
                     state <= IDLE;
                     cs_n  <= CS_N_RST;
                     busy  <= BUSY_RST;
                     sdo   <= SDO_RST;
                     done  <= 1'b1;
                  end
               end
            end
`endif

            default: begin
               state <= IDLE;
               cs_n  <= CS_N_RST;
               sclk  <= SCLK_RST;
               sdo   <= SDO_RST;
               busy  <= BUSY_RST;
            end
         endcase
      end
   end

endmodule : cnt_snapshot_serializer

// File: tb/tb_cnt_snapshot_serializer.sv
// tb_cnt_snapshot_serializer
//   Scoreboard bench: the stimulus side keeps a cycle-level availability
//   model and pushes each word it expects to be captured; a monitor
//   reassembles frames from the serial pins and compares against the queue.
module tb_cnt_snapshot_serializer;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned HP    = 2;
`ifdef SER_PARITY_EN
   localparam int unsigned NBITS = WIDTH + 1;
`else
   localparam int unsigned NBITS = WIDTH;
`endif
   localparam int unsigned FRAME_CYC = 2 * HP * NBITS;

   logic             clk = 1'b0;
   logic             arst;
   logic             start;
   logic [WIDTH-1:0] cnt_in;
   logic             busy, done, cs_n, sclk, sdo;

   always #5 clk = ~clk;

   cnt_snapshot_serializer #(
      .WIDTH       (WIDTH),
      .HALF_PERIOD (HP)
   ) dut (
      .clk    (clk),
      .arst   (arst),
      .cnt_in (cnt_in),
      .start  (start),
      .busy   (busy),
      .done   (done),
      .cs_n   (cs_n),
      .sclk   (sclk),
      .sdo    (sdo)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected serial bit sequence for a captured word, MSB first.
   function automatic logic [NBITS-1:0] frame_bits(input logic [WIDTH-1:0] d);
`ifdef SER_PARITY_EN
      return {d, ^d};
`else
      return d;
`endif
   endfunction

   // ---------------- reference model / scoreboard ----------------
   logic [WIDTH-1:0] exp_q[$];
   int unsigned      blocked = 0;  // edges until a new request can be taken
   int               pushed  = 0;
   int               popped  = 0;

   // One clock: the model sees the inputs the DUT sees at this edge.
   task automatic cyc();
      @(posedge clk);
      if (arst) begin
         blocked = 0;
      end else if (blocked > 0) begin
         blocked--;
      end else if (start) begin
         exp_q.push_back(cnt_in);
         pushed++;
         blocked = FRAME_CYC;
      end
      #1;
   endtask

   task automatic wait_idle(input string name);
      int unsigned n = 0;
      while (!(blocked == 0 && exp_q.size() == 0) && n < 8 * FRAME_CYC) begin
         cyc();
         n++;
      end
      chk({name, "_timeout"}, (blocked == 0 && exp_q.size() == 0), 1);
      repeat (2) cyc();
   endtask

   // ---------------- monitor ----------------
   logic             prev_sclk = 0, prev_busy = 0, prev_sdo = 0, prev_cs_n = 1;
   int unsigned      busy_len = 0, nbits = 0, gap = 0, last_gap = 0, done_cnt = 0;
   logic [NBITS-1:0] bits = '0;
   logic [WIDTH-1:0] exp_w;

   always @(negedge clk) begin
      if (arst) begin
         chk("rst_vals", {cs_n, sclk, sdo, busy, done}, 5'b10000);
         busy_len = 0; nbits = 0; bits = '0; gap = 0;
         prev_sclk = 0; prev_busy = 0; prev_sdo = 0; prev_cs_n = 1;
      end else begin
         if (busy) busy_len++;
         chk("cs_vs_busy", cs_n, !busy);
         if (!busy) chk("idle_lines", {sclk, sdo}, 2'b00);
         if (sclk && !prev_sclk) begin
            chk("rise_time", busy_len, HP + 1 + 2 * HP * nbits);
            chk("sdo_setup", sdo, prev_sdo);
            bits = {bits[NBITS-2:0], sdo};
            nbits++;
         end
         if (sclk && prev_sclk) chk("sdo_hold", sdo, prev_sdo);
         if (done) begin
            done_cnt++;
            chk("done_at_busy_fall", (prev_busy && !busy), 1);
         end
         if (prev_busy && !busy) begin
            chk("done_pulse", done, 1);
            if (exp_q.size() == 0) begin
               chk("unexpected_frame", bits, '1 ^ bits);
            end else begin
               exp_w = exp_q.pop_front();
               popped++;
               chk("frame_data", bits, frame_bits(exp_w));
               chk("frame_bits", nbits, NBITS);
               chk("busy_len", busy_len, FRAME_CYC);
            end
            busy_len = 0; nbits = 0; bits = '0;
         end
         if (!cs_n && prev_cs_n) begin
            last_gap = gap;
            gap = 0;
         end else if (cs_n) begin
            gap++;
         end
         prev_sclk = sclk; prev_busy = busy; prev_sdo = sdo; prev_cs_n = cs_n;
      end
   end

   // ---------------- stimulus ----------------
   task automatic one_frame(input logic [WIDTH-1:0] v);
      cnt_in = v;
      start  = 1'b1;
      cyc();
      start  = 1'b0;
   endtask

   initial begin
      arst = 1'b1; start = 1'b0; cnt_in = '0;
      cyc();
      chk("reset_values", {cs_n, sclk, sdo, busy, done}, 5'b10000);
      repeat (2) cyc();
      arst = 1'b0;
      for (int i = 0; i < 50; i++) begin
         cyc();
         chk("idle_after_reset", {cs_n, sclk, sdo, busy, done}, 5'b10000);
      end

      // basic frame
      one_frame(8'hA5);
      wait_idle("basic");
      chk("basic_frames", popped, 1);

      // requests and cnt_in changes during a frame are ignored
      one_frame(8'hA5);
      repeat (9) cyc();
      cnt_in = 8'h3C; start = 1'b1;
      cyc();
      start = 1'b0;
      repeat (5) cyc();
      cnt_in = 8'hFF;
      wait_idle("ignore");
      chk("ignore_frames", popped, 2);

      // back-to-back with start held high
      cnt_in = 8'h01; start = 1'b1;
      cyc();
      cnt_in = 8'hFF;
      for (int i = 0; i < 4 * FRAME_CYC && pushed < 4; i++) cyc();
      start = 1'b0;
      wait_idle("b2b");
      chk("b2b_frames", popped, 4);
      chk("b2b_cs_gap", last_gap, 1);
      chk("b2b_done_cnt", done_cnt, 4);

      // reset in the middle of a frame
      one_frame(8'h5A);
      for (int i = 0; i < 4 * FRAME_CYC && nbits < 3; i++) cyc();
      chk("mid_reached_bit3", nbits, 3);
      arst = 1'b1;
      #1;
      chk("rst_mid_outputs", {cs_n, sclk, sdo, busy, done}, 5'b10000);
      pushed -= exp_q.size();
      exp_q.delete();
      repeat (2) cyc();
      arst = 1'b0;
      cyc();
      chk("no_done_on_abort", done_cnt, 4);
      one_frame(8'hC3);
      wait_idle("post_reset");
      chk("post_reset_frames", popped, 5);

      // parity corner values (plain data frames without the option)
      one_frame(8'h07);
      wait_idle("w07");
      one_frame(8'h00);
      wait_idle("w00");
      one_frame(8'hFF);
      wait_idle("wFF");

      // randomized requests and input churn
      for (int i = 0; i < 1500; i++) begin
         start  = ($urandom_range(0, 3) == 0);
         cnt_in = WIDTH'($urandom);
         cyc();
      end
      start = 1'b0;
      wait_idle("random");

      chk("all_frames_seen", popped, pushed);
      chk("done_count", done_cnt, popped);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

endmodule : tb_cnt_snapshot_serializer
